// File: rtl/calc_n.sv
// Four-function decimal calculator: keypad command decoding, sequential mul/div,
// and a digit-serial BCD refresh of the accumulator after every accepted command.
module calc_n #(
  parameter int DIGITS = 8,
  parameter int W      = 27
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                cmd,
  input  logic                      cmd_valid,
  output logic [1:0]                status,
  output logic [3:0]                data,
  output logic [$clog2(DIGITS)-1:0] pos,
  output logic                      disp_valid,
  output logic                      neg,
  output logic [2:0]                EA
);
  localparam int PW = $clog2(DIGITS);
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0]  MAX      = W'(10**DIGITS - 1);
  localparam logic [PW-1:0] LAST_POS = PW'(DIGITS - 1);
  localparam logic [CW-1:0] LASTSTEP = CW'(W - 1);
  localparam logic [3:0]    CMD_EQ   = 4'd14;
  localparam logic [3:0]    CMD_BKSP = 4'd15;

  typedef enum logic [2:0] {WAIT_A = 3'd0, WAIT_B = 3'd1, CALC = 3'd2, RESULT = 3'd3, ERR = 3'd4} state_t;
  typedef enum logic [1:0] {ST_ERROR = 2'b00, ST_BUSY = 2'b01, ST_READY = 2'b10} status_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t          state, nx_state;
  status_t         st;
  op_t             op, nx_op, cmd_op;
  logic [W-1:0]    acc, nx_acc, rega, nx_rega, regb, nx_regb, rem;
  logic            nx_neg, entered, nx_entered, boot, start_ref, accept;
  logic [2*W-1:0]  p, nx_p, mul_next, div_next;
  logic [CW-1:0]   cnt, nx_cnt;
  logic [W+3:0]    digit_sum;
  logic [W:0]      add_sum, mul_acc, div_shift;
  logic [W-1:0]    div_sub;
  logic            div_ge;

  assign status = st;
  assign EA     = state;
  assign accept = cmd_valid && (st == ST_READY);
  // operator codes 10..13 map onto ADD..DIV
  assign cmd_op = op_t'(cmd[1:0] - 2'd2);

  always_comb begin
    digit_sum = {4'b0, acc} * (W+4)'(10) + {{W{1'b0}}, cmd};
    add_sum   = {1'b0, rega} + {1'b0, regb};
    mul_acc   = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, rega} : '0);
    mul_next  = {mul_acc, p[W-1:1]};
    div_shift = {p[2*W-1:W], p[W-1]};
    div_ge    = div_shift >= {1'b0, regb};
    div_sub   = div_ge ? W'(div_shift - {1'b0, regb}) : div_shift[W-1:0];
    div_next  = {div_sub, p[W-2:0], div_ge};
  end

  always_comb begin
    nx_state   = state;
    nx_acc     = acc;
    nx_rega    = rega;
    nx_regb    = regb;
    nx_op      = op;
    nx_neg     = neg;
    nx_entered = entered;
    nx_p       = p;
    nx_cnt     = cnt;
    start_ref  = boot;
    case (state)
      WAIT_A, WAIT_B: if (accept) begin
        if (cmd <= 4'd9) begin
          start_ref = 1'b1;
          if (digit_sum <= (W+4)'(MAX)) begin
            nx_acc     = digit_sum[W-1:0];
            nx_entered = 1'b1;
          end
        end else if (cmd == CMD_BKSP) begin
          start_ref = 1'b1;
          nx_acc    = acc / W'(10);
        end else if (cmd == CMD_EQ) begin
          if (state == WAIT_A) start_ref = 1'b1;
          else begin
            nx_regb  = acc;
            nx_state = CALC;
            nx_cnt   = '0;
            nx_p     = (op == OP_DIV) ? {{W{1'b0}}, rega} : {{W{1'b0}}, acc};
          end
        end else if (state == WAIT_A) begin
          start_ref  = 1'b1;
          nx_rega    = acc;
          nx_op      = cmd_op;
          nx_acc     = '0;
          nx_entered = 1'b0;
          nx_state   = WAIT_B;
        end else if (!entered) begin
          start_ref = 1'b1;
          nx_op     = cmd_op;
        end else nx_state = ERR;
      end
      CALC: begin
        nx_neg = 1'b0;
        case (op)
          OP_ADD: if (add_sum > {1'b0, MAX}) nx_state = ERR;
                  else begin
                    nx_acc    = add_sum[W-1:0];
                    nx_state  = RESULT;
                    start_ref = 1'b1;
                  end
          OP_SUB: begin
            nx_acc    = (rega < regb) ? regb - rega : rega - regb;
            nx_neg    = rega < regb;
            nx_state  = RESULT;
            start_ref = 1'b1;
          end
          OP_MUL: begin
            nx_p   = mul_next;
            nx_cnt = cnt + CW'(1);
            if (cnt == LASTSTEP) begin
              if (mul_next > {{W{1'b0}}, MAX}) nx_state = ERR;
              else begin
                nx_acc    = mul_next[W-1:0];
                nx_state  = RESULT;
                start_ref = 1'b1;
              end
            end
          end
          OP_DIV: if (regb == '0) nx_state = ERR;
                  else begin
                    nx_p   = div_next;
                    nx_cnt = cnt + CW'(1);
                    if (cnt == LASTSTEP) begin
                      if (div_next[W-1:0] > MAX) nx_state = ERR;
                      else begin
                        nx_acc    = div_next[W-1:0];
                        nx_state  = RESULT;
                        start_ref = 1'b1;
                      end
                    end
                  end
        endcase
      end
      RESULT: if (accept) begin
        start_ref = 1'b1;
        if (cmd <= 4'd9) begin
          nx_acc   = {{(W-4){1'b0}}, cmd};
          nx_neg   = 1'b0;
          nx_state = WAIT_A;
        end else if (cmd <= 4'd13 && !neg) begin
          nx_rega    = acc;
          nx_op      = cmd_op;
          nx_acc     = '0;
          nx_entered = 1'b0;
          nx_state   = WAIT_B;
        end
      end
      ERR: ;
      default: nx_state = ERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= WAIT_A;
      acc        <= '0;
      rega       <= '0;
      regb       <= '0;
      op         <= OP_ADD;
      neg        <= 1'b0;
      entered    <= 1'b0;
      p          <= '0;
      cnt        <= '0;
      rem        <= '0;
      pos        <= '0;
      data       <= '0;
      disp_valid <= 1'b0;
      st         <= ST_BUSY;
      boot       <= 1'b1;
    end else begin
      state   <= nx_state;
      acc     <= nx_acc;
      rega    <= nx_rega;
      regb    <= nx_regb;
      op      <= nx_op;
      neg     <= nx_neg;
      entered <= nx_entered;
      p       <= nx_p;
      cnt     <= nx_cnt;
      boot    <= 1'b0;
      // digit 0 comes straight from the next accumulator; later digits from rem
      if (nx_state == ERR) begin
        st         <= ST_ERROR;
        disp_valid <= 1'b0;
      end else if (start_ref) begin
        st         <= ST_BUSY;
        disp_valid <= 1'b1;
        pos        <= '0;
        data       <= 4'(nx_acc % W'(10));
        rem        <= nx_acc / W'(10);
      end else if (accept) begin
        st <= ST_BUSY;
      end else if (disp_valid) begin
        if (pos == LAST_POS) begin
          disp_valid <= 1'b0;
          st         <= ST_READY;
        end else begin
          pos  <= pos + PW'(1);
          data <= 4'(rem % W'(10));
          rem  <= rem / W'(10);
        end
      end
    end
  end
endmodule

// File: tb/tb_calc_n.sv
// Randomized and directed bench for calc_n against an arithmetic model of the
// calculator's keypad rules.
module tb_calc_n;
  localparam int     DIGITS = 8;
  localparam int     W      = 27;
  localparam longint MAXV   = 99999999;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [1:0] status;
  logic [3:0] data;
  logic [$clog2(DIGITS)-1:0] pos;
  logic       disp_valid, neg;
  logic [2:0] EA;

  int total = 0;
  int bad   = 0;

  // model: mode uses the externally visible state codes
  int     m_mode, m_op;
  longint m_acc, m_a, m_b, shown;
  bit     m_neg, m_ent;

  calc_n #(.DIGITS(DIGITS), .W(W)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .status(status), .data(data), .pos(pos), .disp_valid(disp_valid),
    .neg(neg), .EA(EA)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int c, output int calc, output bit err);
    longint r = 0;
    calc = 0;
    err  = 0;
    case (m_mode)
      0, 1: begin
        if (c <= 9) begin
          if (m_acc * 10 + c <= MAXV) begin m_acc = m_acc * 10 + c; m_ent = 1; end
        end else if (c == 15) m_acc = m_acc / 10;
        else if (c == 14) begin
          if (m_mode == 1) begin
            m_b  = m_acc;
            calc = (m_op >= 12) ? W : 1;
            case (m_op)
              10: r = m_a + m_b;
              11: r = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
              12: r = m_a * m_b;
              default: if (m_b == 0) begin err = 1; calc = 1; end else r = m_a / m_b;
            endcase
            if (r > MAXV) err = 1;
            if (err) m_mode = 4;
            else begin
              m_acc  = r;
              m_neg  = (m_op == 11) && (m_a < m_b);
              m_mode = 3;
            end
          end
        end else if (m_mode == 0) begin
          m_a = m_acc; m_op = c; m_acc = 0; m_ent = 0; m_mode = 1;
        end else if (!m_ent) m_op = c;
        else begin err = 1; m_mode = 4; end
      end
      3: begin
        if (c <= 9) begin m_acc = c; m_neg = 0; m_mode = 0; end
        else if (c <= 13 && !m_neg) begin m_a = m_acc; m_op = c; m_acc = 0; m_ent = 0; m_mode = 1; end
      end
      default: ;
    endcase
  endtask

  task automatic pulse(input int c);
    cmd       = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Called one sample after the accepting edge; optional extra pulse mid-refresh.
  task automatic observe(input int calc_exp, input bit err_exp, input int inject);
    int     n = 0;
    int     seqbad = 0;
    longint val = 0, scale = 1, last;
    while (EA == 3'd2 && n < 2 * W) begin
      if (status != 2'b01 || disp_valid) seqbad++;
      n++;
      @(negedge clock);
    end
    check("calc_len", n, calc_exp);
    if (err_exp) begin
      check("err_status", status, 0);
      check("err_ea", EA, 4);
      check("err_dv", disp_valid, 0);
      return;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (!disp_valid || pos != i || status != 2'b01 || data > 9) seqbad++;
      val += data * scale;
      scale *= 10;
      cmd_valid = (inject >= 0 && i == 2);
      cmd = 4'(inject);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    last = m_acc;
    repeat (DIGITS - 1) last = last / 10;
    check("refresh_seq", seqbad, 0);
    check("disp", val, m_acc);
    check("neg", neg, m_neg);
    check("ea", EA, m_mode);
    check("ready", status, 2);
    check("dv_off", disp_valid, 0);
    check("hold_pos", pos, DIGITS - 1);
    check("hold_data", data, last % 10);
    shown = val;
  endtask

  task automatic run_cmd(input int c, input int inject);
    int calc;
    bit err;
    if (m_mode == 4) begin
      pulse(c);
      repeat (2) @(negedge clock);
      check("err_hold", status, 0);
      check("err_hold_dv", disp_valid, 0);
      check("err_hold_ea", EA, 4);
      return;
    end
    model(c, calc, err);
    pulse(c);
    observe(calc, err, inject);
  endtask

  task automatic run_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte ch;
      int  c;
      ch = s[i];
      case (ch)
        "+": c = 10;
        "-": c = 11;
        "*": c = 12;
        "/": c = 13;
        "=": c = 14;
        "<": c = 15;
        default: c = ch - "0";
      endcase
      run_cmd(c, -1);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    repeat (cycles) @(negedge clock);
    check("rst_status", status, 1);
    check("rst_ea", EA, 0);
    check("rst_dv", disp_valid, 0);
    check("rst_pos", pos, 0);
    check("rst_data", data, 0);
    check("rst_neg", neg, 0);
    m_mode = 0; m_acc = 0; m_a = 0; m_b = 0; m_op = 10; m_neg = 0; m_ent = 0;
    reset = 1'b1;
    @(negedge clock);
    observe(0, 0, -1);
  endtask

  initial begin
    @(negedge clock);
    do_reset(2);

    run_str("12+34=");
    check("req032_val", shown, 46);
    check("req032_neg", neg, 0);

    do_reset(2);
    run_str("5-12=");
    check("req033_val", shown, 7);
    check("req033_neg", neg, 1);
    run_str("+");
    check("req033_ea", EA, 3);

    do_reset(2);
    run_str("9999*9999=");
    check("req034_mul", shown, 99980001);
    run_str("99999999+1=");
    check("req034_err", status, 0);
    run_str("5");

    do_reset(2);
    run_str("100/7=");
    check("req035_div", shown, 14);
    run_str("7/0=");
    check("req035_div0", status, 0);
    do_reset(2);
    run_str("123<");
    check("req035_bksp", shown, 12);
    do_reset(2);
    run_str("999999999");
    check("req035_max", shown, 99999999);

    // a digit pulsed while busy must be dropped
    do_reset(2);
    run_cmd(5, 7);
    run_cmd(15, -1);
    check("drop_busy", shown, 0);

    // reset during the tenth multiply cycle
    do_reset(2);
    run_str("9999*9999");
    pulse(14);
    repeat (9) @(negedge clock);
    check("midcalc_ea", EA, 2);
    do_reset(1);

    for (int k = 0; k < 300; k++) begin
      int r, c;
      r = int'($urandom_range(0, 99));
      if (r < 55)      c = int'($urandom_range(0, 9));
      else if (r < 75) c = 10 + int'($urandom_range(0, 3));
      else if (r < 87) c = 14;
      else             c = 15;
      if (m_mode == 4) begin
        run_cmd(c, -1);
        do_reset(int'($urandom_range(1, 3)));
      end else run_cmd(c, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
